mem_bus_ctrl: RTL and testbench
===============================

MEM_BUS_CTRL -- requirements
Module: mem_bus_ctrl

Interface
REQ-001 The block SHALL have port `clk`, input, 1 bit: single clock; all state changes occur on its rising edge.
REQ-002 The block SHALL have port `rst`, input, 1 bit: reset, asynchronous, active-high.
REQ-003 The block SHALL have port `req_valid`, input, 1 bit: requester presents a command.
REQ-004 The block SHALL have port `req_ready`, output, 1 bit: block accepts a command this cycle.
REQ-005 The block SHALL have port `req_we`, input, 1 bit: 1 = write, 0 = read.
REQ-006 The block SHALL have port `req_addr`, input, 10 bits: word address, 0..1023.
REQ-007 The block SHALL have port `req_wdata`, input, 12 bits: write data.
REQ-008 The block SHALL have port `rsp_valid`, output, 1 bit: response available.
REQ-009 The block SHALL have port `rsp_ready`, input, 1 bit: requester consumes the response.
REQ-010 The block SHALL have port `rsp_data`, output, 12 bits: read data, or write data for a write.
REQ-011 The block SHALL have port `rsp_err`, output, 1 bit: read-back mismatch; constant 0 without READBACK_CHECK_EN.
REQ-012 The block SHALL have port `mem_address`, output, 10 bits: memory address bus.
REQ-013 The block SHALL have port `mem_re`, output, 1 bit: memory read enable.
REQ-014 The block SHALL have port `mem_we`, output, 1 bit: memory write enable.
REQ-015 The block SHALL have port `mem_data`, inout, 12 bits: shared memory data bus, driven by this block only during WR and high-Z otherwise.

Function
REQ-016 The FSM SHALL have states IDLE, WR, TURN, RD, RESP (plus CHK with READBACK_CHECK_EN), with `req_ready`=1 only in IDLE.
REQ-017 A command SHALL be accepted on the edge where `req_valid` and `req_ready` are both 1; `req_addr`, `req_we` and `req_wdata` are registered at that edge, and input changes afterwards are ignored.
REQ-018 On an accepted write, the FSM SHALL go IDLE->WR, where `mem_we`=1, `mem_address` is the registered address, and `mem_data` is the registered data, for exactly one cycle; the memory captures at the edge leaving WR.
REQ-019 Without the macro, WR->RESP SHALL hold, with `rsp_data`=write data and `rsp_err`=0.
REQ-020 On an accepted read, the FSM SHALL go IDLE->RD, where `mem_re`=1 for exactly one cycle and `mem_data` is high-Z; `mem_data` is sampled into `rsp_data` at the edge leaving RD, then the FSM goes RD->RESP.
REQ-021 In RESP, `rsp_valid`=1 and `rsp_data`/`rsp_err` SHALL stay stable until `rsp_ready`=1; the FSM then goes RESP->IDLE on that edge.
REQ-022 Latency SHALL be: read response valid 2 cycles after acceptance; write response valid 2 cycles after acceptance without the macro, 4 cycles with it.
REQ-023 `mem_re` and `mem_we` SHALL never both be 1; TURN is one idle cycle with both low and the bus high-Z, inserted whenever a read follows a write inside one command.
REQ-024 Outside WR and RD, `mem_re`=0, `mem_we`=0, and `mem_address` SHALL hold its last value.
REQ-025 Back-to-back commands SHALL be allowed; the next command is accepted in the IDLE cycle after a RESP handshake, with no bus conflict at the write-to-read boundary because of IDLE.
REQ-026 Addresses 0 and 1023 SHALL be handled identically to other addresses, with no wrap or increment.

Reset
REQ-027 While `rst`=1, the block SHALL be in IDLE with `req_ready`=1, `rsp_valid`=0, `rsp_data`=0, `rsp_err`=0, `mem_re`=0, `mem_we`=0, `mem_address`=0, and `mem_data` high-Z.
REQ-028 A reset asserted mid-command SHALL abort it immediately (asynchronously), drop `mem_we` in the same cycle, and discard any pending response.

Configuration
REQ-029 Macro READBACK_CHECK_EN SHALL control read-back checking: when defined, a write SHALL go WR->TURN->CHK, where CHK asserts `mem_re` for one cycle and compares the sampled data with the written data, then CHK->RESP with `rsp_data`=read-back value and `rsp_err`=(mismatch).
REQ-030 When READBACK_CHECK_EN is undefined, the TURN-after-write and CHK states SHALL be absent and `rsp_err` SHALL be tied to 0.

Verification
REQ-031 The bench SHALL cover write 0x5A3 to address 0x000, then read 0x000: `mem_we` is high for 1 cycle, and the read response has `rsp_data`=0x5A3 two cycles after acceptance.
REQ-032 The bench SHALL cover write 0xFFF to address 0x3FF, then read 0x3FF: `rsp_data`=0xFFF, and address 0x3FE is unchanged.
REQ-033 The bench SHALL cover a read with `rsp_ready` held low for 5 cycles: `rsp_valid` and `rsp_data` stay stable, `req_ready`=0, and a second `req_valid` is ignored until the handshake.
REQ-034 The bench SHALL cover `rst` pulsed during WR: `mem_we` drops asynchronously, and after release `req_ready`=1 and `rsp_valid`=0.
REQ-035 The bench SHALL cover, with READBACK_CHECK_EN defined, a write of 0x123 with the memory model forced to return 0x120: `rsp_err`=1 and `rsp_data`=0x120 four cycles after acceptance; with a correct model, `rsp_err`=0.
REQ-036 The bench SHALL cover alternating write/read commands for 20 cycles: `mem_re`&&`mem_we` is never 1, and `mem_data` is never driven while `mem_re`=1.

Source files
------------

// File: rtl/mem_bus_ctrl.sv
// mem_bus_ctrl: one command at a time to a single-port memory over a shared tri-state data bus.
// Define READBACK_CHECK_EN to re-read every write and flag a data mismatch on rsp_err.
module mem_bus_ctrl (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [9:0]  req_addr,
  input  logic [11:0] req_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [11:0] rsp_data,
  output logic        rsp_err,
  output logic [9:0]  mem_address,
  output logic        mem_re,
  output logic        mem_we,
  inout  wire  [11:0] mem_data
);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    WR   = 3'd1,
    TURN = 3'd2,
    RD   = 3'd3,
    RESP = 3'd4
`ifdef READBACK_CHECK_EN
    , CHK = 3'd5
`endif
  } state_e;

  state_e      state_q, state_d;
  logic [9:0]  addr_q, addr_d;
  logic [11:0] wdata_q, wdata_d;
  logic [11:0] rsp_data_q, rsp_data_d;
  logic        rsp_valid_q, rsp_valid_d;
  logic        req_ready_q, req_ready_d;
  logic        mem_re_q, mem_re_d;
  logic        mem_we_q, mem_we_d;
`ifdef READBACK_CHECK_EN
  logic        rsp_err_q, rsp_err_d;
`endif

  // Next-state and next-output computation; every output is a flop loaded from its _d value.
  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    rsp_data_d = rsp_data_q;
`ifdef READBACK_CHECK_EN
    rsp_err_d  = rsp_err_q;
`endif
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          addr_d  = req_addr;
          wdata_d = req_wdata;
          state_d = req_we ? WR : RD;
        end else begin
          state_d = IDLE;
        end
      end
      WR: begin
`ifdef READBACK_CHECK_EN
        state_d = TURN;
`else
        state_d    = RESP;
        rsp_data_d = wdata_q;
`endif
      end
      TURN: begin
`ifdef READBACK_CHECK_EN
        state_d = CHK;
`else
        state_d = IDLE;
`endif
      end
`ifdef READBACK_CHECK_EN
      CHK: begin
        state_d    = RESP;
        rsp_data_d = mem_data;
        rsp_err_d  = (mem_data != wdata_q);
      end
`endif
      RD: begin
        state_d    = RESP;
        rsp_data_d = mem_data;
`ifdef READBACK_CHECK_EN
        rsp_err_d  = 1'b0;
`endif
      end
      RESP: begin
        if (rsp_ready) begin
          state_d = IDLE;
        end else begin
          state_d = RESP;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Bus strobes follow the state being entered so they are valid for that whole cycle.
    req_ready_d = (state_d == IDLE);
    rsp_valid_d = (state_d == RESP);
    mem_we_d    = (state_d == WR);
`ifdef READBACK_CHECK_EN
    mem_re_d    = (state_d == RD) || (state_d == CHK);
`else
    mem_re_d    = (state_d == RD);
`endif
  end

  // State and registered outputs; reset aborts any command and releases the bus at once.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      addr_q      <= 10'd0;
      wdata_q     <= 12'd0;
      rsp_data_q  <= 12'd0;
      rsp_valid_q <= 1'b0;
      req_ready_q <= 1'b1;
      mem_re_q    <= 1'b0;
      mem_we_q    <= 1'b0;
`ifdef READBACK_CHECK_EN
      rsp_err_q   <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      rsp_data_q  <= rsp_data_d;
      rsp_valid_q <= rsp_valid_d;
      req_ready_q <= req_ready_d;
      mem_re_q    <= mem_re_d;
      mem_we_q    <= mem_we_d;
`ifdef READBACK_CHECK_EN
      rsp_err_q   <= rsp_err_d;
`endif
    end
  end

  assign req_ready   = req_ready_q;
  assign rsp_valid   = rsp_valid_q;
  assign rsp_data    = rsp_data_q;
  assign mem_address = addr_q;
  assign mem_re      = mem_re_q;
  assign mem_we      = mem_we_q;
`ifdef READBACK_CHECK_EN
  assign rsp_err     = rsp_err_q;
`else
  assign rsp_err     = 1'b0;
`endif

  // The data bus is driven only while the write strobe is up, so it can never clash with a read.
  assign mem_data = mem_we_q ? wdata_q : {12{1'bz}};

endmodule

// File: tb/tb_mem_bus_ctrl.sv
// Randomized self-checking bench for mem_bus_ctrl against a command-level memory reference model.
// Honours READBACK_CHECK_EN for write latency and read-back error checks.
module tb_mem_bus_ctrl;

  logic        clk;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [9:0]  req_addr;
  logic [11:0] req_wdata;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [11:0] rsp_data;
  logic        rsp_err;
  logic [9:0]  mem_address;
  logic        mem_re;
  logic        mem_we;
  tri   [11:0] mem_data;

  int total = 0;
  int bad   = 0;

  logic [11:0] bus_mem [0:1023];
  logic [11:0] ref_mem [0:1023];
  logic        mem_fill;
  logic        corrupt_en;
  logic        mon_en;

  mem_bus_ctrl dut (
    .clk         (clk),
    .rst         (rst),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_we      (req_we),
    .req_addr    (req_addr),
    .req_wdata   (req_wdata),
    .rsp_valid   (rsp_valid),
    .rsp_ready   (rsp_ready),
    .rsp_data    (rsp_data),
    .rsp_err     (rsp_err),
    .mem_address (mem_address),
    .mem_re      (mem_re),
    .mem_we      (mem_we),
    .mem_data    (mem_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [11:0] fill_pat(input int i);
    logic [31:0] h;
    h = i * 32'd2654435761 + 32'd12345;
    return h[31:20];
  endfunction

  // Asynchronous-read memory: drives the bus only while read is enabled.
  assign mem_data = mem_re ? (corrupt_en ? (bus_mem[mem_address] ^ 12'h003) : bus_mem[mem_address])
                           : {12{1'bz}};

  always @(posedge clk) begin
    if (mem_fill) begin
      for (int i = 0; i < 1024; i++) bus_mem[i] <= fill_pat(i);
    end else if (mem_we) begin
      bus_mem[mem_address] <= mem_data;
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h @%0t", tag, got, exp, $time);
    end
  endtask

  // Read and write strobes must be mutually exclusive on every cycle.
  always @(negedge clk) begin
    if (mon_en) chk("re_we_exclusive", {31'd0, mem_re & mem_we}, 32'd0);
  end

  // One full command: issue at a negedge, check latency/strobes/response, handshake, end on a negedge.
  task automatic do_cmd(input logic we, input logic [9:0] a, input logic [11:0] d,
                        input int hold, input logic spurious);
    logic [11:0] exp_data;
    logic        exp_err;
    int          exp_lat, exp_re, lat, we_cnt, re_cnt;
    logic        done;
    if (we) begin
`ifdef READBACK_CHECK_EN
      exp_data = corrupt_en ? (d ^ 12'h003) : d;
      exp_err  = corrupt_en;
      exp_lat  = 4;
      exp_re   = 1;
`else
      exp_data = d;
      exp_err  = 1'b0;
      exp_lat  = 2;
      exp_re   = 0;
`endif
      ref_mem[a] = d;
    end else begin
      exp_data = ref_mem[a];
      exp_err  = 1'b0;
      exp_lat  = 2;
      exp_re   = 1;
    end
    chk("req_ready_idle", {31'd0, req_ready}, 32'd1);
    req_valid = 1'b1;
    req_we    = we;
    req_addr  = a;
    req_wdata = d;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    req_we    = 1'($urandom);
    req_addr  = 10'($urandom);
    req_wdata = 12'($urandom);
    lat = 0; we_cnt = 0; re_cnt = 0; done = 1'b0;
    while (!done && lat < 12) begin
      @(negedge clk);
      lat++;
      if (mem_we) begin
        we_cnt++;
        chk("wr_address", {22'd0, mem_address}, {22'd0, a});
      end
      if (mem_re) begin
        re_cnt++;
        chk("rd_address", {22'd0, mem_address}, {22'd0, a});
      end
      if (rsp_valid) done = 1'b1;
    end
    chk("rsp_latency", lat, exp_lat);
    if (!done) return;
    chk("we_cycles", we_cnt, we ? 1 : 0);
    chk("re_cycles", re_cnt, exp_re);
    chk("rsp_data", {20'd0, rsp_data}, {20'd0, exp_data});
    chk("rsp_err", {31'd0, rsp_err}, {31'd0, exp_err});
    if (spurious) begin
      req_valid = 1'b1;
      req_we    = 1'b1;
      req_addr  = a ^ 10'h155;
      req_wdata = ~ref_mem[a ^ 10'h155];
    end
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      chk("hold_valid", {31'd0, rsp_valid}, 32'd1);
      chk("hold_data", {20'd0, rsp_data}, {20'd0, exp_data});
      chk("hold_ready", {31'd0, req_ready}, 32'd0);
      chk("hold_no_we", {31'd0, mem_we}, 32'd0);
    end
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    rsp_ready = 1'b0;
    @(negedge clk);
    chk("post_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    chk("post_req_ready", {31'd0, req_ready}, 32'd1);
  endtask

  initial begin
    int          mism;
    logic        we;
    logic [9:0]  a;
    logic [11:0] d;
    int          sel;
    rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_addr = 10'd0; req_wdata = 12'd0;
    rsp_ready = 1'b0; corrupt_en = 1'b0; mon_en = 1'b0; mem_fill = 1'b1;
    for (int i = 0; i < 1024; i++) ref_mem[i] = fill_pat(i);
    @(posedge clk);
    #1 mem_fill = 1'b0;
    @(negedge clk);
    chk("rst_req_ready", {31'd0, req_ready}, 32'd1);
    chk("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    chk("rst_rsp_data", {20'd0, rsp_data}, 32'd0);
    chk("rst_rsp_err", {31'd0, rsp_err}, 32'd0);
    chk("rst_mem_re", {31'd0, mem_re}, 32'd0);
    chk("rst_mem_we", {31'd0, mem_we}, 32'd0);
    chk("rst_mem_addr", {22'd0, mem_address}, 32'd0);
    rst = 1'b0;
    mon_en = 1'b1;
    @(negedge clk);

    // Lowest address, then highest address with its neighbour untouched.
    do_cmd(1'b1, 10'h000, 12'h5A3, 0, 1'b0);
    do_cmd(1'b0, 10'h000, 12'h000, 0, 1'b0);
    do_cmd(1'b1, 10'h3FF, 12'hFFF, 0, 1'b0);
    do_cmd(1'b0, 10'h3FF, 12'h000, 0, 1'b0);
    do_cmd(1'b0, 10'h3FE, 12'h000, 0, 1'b0);

    // Stalled response with a competing request that must be ignored.
    do_cmd(1'b0, 10'h123, 12'h000, 5, 1'b1);
    do_cmd(1'b0, 10'h123 ^ 10'h155, 12'h000, 0, 1'b0);

    // Reset pulse in the middle of a write: strobe drops without waiting for a clock edge.
    req_valid = 1'b1; req_we = 1'b1; req_addr = 10'h0AB; req_wdata = ~ref_mem[10'h0AB];
    @(posedge clk);
    #1 req_valid = 1'b0;
    chk("wr_strobe_up", {31'd0, mem_we}, 32'd1);
    #2 rst = 1'b1;
    #1;
    chk("rst_async_we", {31'd0, mem_we}, 32'd0);
    chk("rst_async_ready", {31'd0, req_ready}, 32'd1);
    chk("rst_async_valid", {31'd0, rsp_valid}, 32'd0);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("rel_req_ready", {31'd0, req_ready}, 32'd1);
    chk("rel_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    do_cmd(1'b0, 10'h0AB, 12'h000, 0, 1'b0);

`ifdef READBACK_CHECK_EN
    corrupt_en = 1'b1;
    do_cmd(1'b1, 10'h055, 12'h123, 0, 1'b0);
    corrupt_en = 1'b0;
    do_cmd(1'b1, 10'h056, 12'h123, 0, 1'b0);
`endif

    // Alternating writes and reads back-to-back.
    for (int i = 0; i < 10; i++) begin
      a = 10'($urandom);
      d = 12'($urandom);
      do_cmd(1'b1, a, d, 0, 1'b0);
      do_cmd(1'b0, a, 12'h000, 0, 1'b0);
    end

    // Random traffic with address extremes favoured.
    for (int i = 0; i < 40; i++) begin
      we  = 1'($urandom_range(0, 1));
      sel = $urandom_range(0, 3);
      a   = (sel == 0) ? 10'h000 : (sel == 1) ? 10'h3FF : 10'($urandom_range(0, 1023));
      d   = 12'($urandom);
      do_cmd(we, a, d, $urandom_range(0, 3), 1'b0);
    end

    mism = 0;
    for (int i = 0; i < 1024; i++) begin
      if (bus_mem[i] !== ref_mem[i]) mism++;
    end
    chk("mem_image", mism, 0);

    mon_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
